// File: rtl/hilotof_result_arbiter.sv
// hilotof_result_arbiter: round-robin arbiter that funnels up to 16 result
// sources into the single 32-bit result channel of the UART I/O block.
// One word at a time is captured into a registered output stage. The word can
// optionally carry its source index in the top TAG_BITS bits. Completed output
// handshakes are counted in words_sent.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. A producer holds valid and data stable until that edge.
// Ready may depend combinationally on valid, but valid never depends on ready.
//
// FSM state is visible externally: dut_dout_valid is 1 exactly in SEND.
module hilotof_result_arbiter #(
  parameter int N_REQ    = 4,
  parameter int TAG_BITS = 0,
  localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clock,
  input  logic                  sys_reset_n,
  input  logic [32*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  output logic [31:0]           dut_dout,
  output logic                  dut_dout_valid,
  input  logic                  dut_dout_ready,
  output logic [IW-1:0]         grant_id,
  output logic [15:0]           words_sent
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Low bits of a requester word that survive tagging. The whole word survives when TAG_BITS=0.
  localparam logic [31:0] DATA_MASK = 32'hFFFF_FFFF >> TAG_BITS;

  state_t          state;
  state_t          state_nxt;
  logic            run;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   winner;
  logic            found;
  logic [IW:0]     cand_sum;
  logic [IW-1:0]   cand;
  logic [31:0]     win_data;
  logic [31:0]     tag_val;
  logic [31:0]     win_word;
  logic            accept;

  // Round-robin search. Scan offsets from highest to lowest so the last hit
  // is the valid requester closest to rr_ptr.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand_sum = {1'b0, rr_ptr} + (IW+1)'(i);
      cand     = (cand_sum >= (IW+1)'(N_REQ)) ? IW'(cand_sum - (IW+1)'(N_REQ))
                                              : IW'(cand_sum);
      if (req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Select the winner's word and apply the optional source tag.
  // The tag shift is 32 when TAG_BITS=0, so no tag is added.
  always_comb begin
    win_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (winner == IW'(k)) win_data = req_data[32*k +: 32];
    end
    tag_val  = {{(32-IW){1'b0}}, winner} << (32 - TAG_BITS);
    win_word = (win_data & DATA_MASK) | tag_val;
  end

  assign accept         = run && (state == IDLE) && found;
  assign dut_dout_valid = (state == SEND);

  // One-hot accept toward the winning requester, only while idle and running.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  // Next-state logic: IDLE captures a word, SEND waits for the I/O block.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SEND;
      SEND:    if (dut_dout_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register. Reset drops any captured word immediately.
  always_ff @(posedge clock or negedge sys_reset_n) begin
    if (!sys_reset_n) state <= IDLE;
    else              state <= state_nxt;
  end

  // Output stage, round-robin pointer, run flag and delivered-word counter.
  always_ff @(posedge clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      run        <= 1'b0;
      dut_dout   <= '0;
      grant_id   <= '0;
      rr_ptr     <= '0;
      words_sent <= '0;
    end else begin
      run <= 1'b1;
      if (accept) begin
        dut_dout <= win_word;
        grant_id <= winner;
        rr_ptr   <= (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;
      end
      if ((state == SEND) && dut_dout_ready) words_sent <= words_sent + 16'd1;
    end
  end

endmodule
